// File: rtl/conv_sum_sequencer.sv
// Accumulate controller around an external combinational 32-bit adder: sums TAPS product terms per window.
// Optional build macro CONV_SAT_EN clamps the accumulator on signed overflow instead of wrapping.
module conv_sum_sequencer #(
  parameter  int TAPS  = 8,
  localparam int CNT_W = $clog2(TAPS)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        clr,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  input  logic [31:0] add_s,
  input  logic        add_cout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_ovf
);

  typedef enum logic [0:0] {ST_ACCUM = 1'b0, ST_HOLD = 1'b1} state_e;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TAPS - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic [31:0]       out_data_q, out_data_d;
  logic              out_ovf_q, out_ovf_d;

  logic              accept_s;
  logic              ovf_now_s;
  logic              sticky_s;
  logic [31:0]       sum_s;
  logic              unused_cout_s;

  // Signed overflow of a two's-complement add, judged from operand and result sign bits.
  function automatic logic signed_add_ovf(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] s);
    return (a[31] == b[31]) && (s[31] != a[31]);
  endfunction

  // Carry-out is deliberately ignored; only signed overflow matters here.
  assign unused_cout_s = add_cout;

  // Adder operands: first term of a window starts from zero, not the stale accumulator.
  always_comb begin
    add_a = (cnt_q == CNT_ZERO) ? 32'h0000_0000 : acc_q;
    add_b = in_data;
  end

  // State register and datapath flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ACCUM;
      cnt_q      <= CNT_ZERO;
      acc_q      <= 32'h0000_0000;
      ovf_q      <= 1'b0;
      out_data_q <= 32'h0000_0000;
      out_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      out_data_q <= out_data_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

  // Next-state and datapath update; clr outranks both accept and the output handshake.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    out_data_d = out_data_q;
    out_ovf_d  = out_ovf_q;

    accept_s  = in_valid & in_ready & ~clr;
    ovf_now_s = signed_add_ovf(add_a, add_b, add_s);
    sticky_s  = ((cnt_q == CNT_ZERO) ? 1'b0 : ovf_q) | ovf_now_s;
`ifdef CONV_SAT_EN
    if (ovf_now_s) begin
      sum_s = add_a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      sum_s = add_s;
    end
`else
    sum_s = add_s;
`endif

    if (clr) begin
      cnt_d   = CNT_ZERO;
      ovf_d   = 1'b0;
      state_d = ST_ACCUM;
    end else if (accept_s) begin
      acc_d = sum_s;
      ovf_d = sticky_s;
      if (cnt_q == CNT_LAST) begin
        cnt_d      = CNT_ZERO;
        state_d    = ST_HOLD;
        out_data_d = sum_s;
        out_ovf_d  = sticky_s;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (out_ready) begin
            state_d = ST_ACCUM;
          end else begin
            state_d = ST_HOLD;
          end
        end
        ST_ACCUM: state_d = ST_ACCUM;
        default:  state_d = ST_ACCUM;
      endcase
    end
  end

  // Handshake outputs decoded from the registered state.
  always_comb begin
    case (state_q)
      ST_ACCUM: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
      ST_HOLD: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
    endcase
    out_data = out_data_q;
    out_ovf  = out_ovf_q;
  end

endmodule
